// File: rtl/control_decode_pipe_pkg.sv
// Instruction classes, the control bundle carried down the pipe, and the
// result/forwarding select encodings shared by the pipelined control decoder.
package control_decode_pipe_pkg;
    localparam int CTRL_REG_ADDR_W   = 5;
    localparam int CTRL_RESULT_SRC_W = 3;

    typedef enum logic [2:0] {
        REG_COMPUTATION = 3'd0,
        IMM_COMPUTATION = 3'd1,
        LOAD            = 3'd2,
        STORE           = 3'd3,
        UPPER           = 3'd4,
        JUMP            = 3'd5,
        BRANCH          = 3'd6
    } InstructionTypes;

    typedef enum logic [2:0] {
        SUB_NONE         = 3'd0,
        LOAD_UPPER_IMM   = 3'd1,
        ADD_UPPER_IMM_PC = 3'd2,
        BEQ              = 3'd3,
        BNE              = 3'd4
    } InstructionSubTypes;

    localparam logic [CTRL_RESULT_SRC_W-1:0] RESULT_ALU   = 3'b000;
    localparam logic [CTRL_RESULT_SRC_W-1:0] RESULT_MEM   = 3'b001;
    localparam logic [CTRL_RESULT_SRC_W-1:0] RESULT_PC4   = 3'b010;
    localparam logic [CTRL_RESULT_SRC_W-1:0] RESULT_IMM   = 3'b011;
    localparam logic [CTRL_RESULT_SRC_W-1:0] RESULT_PCIMM = 3'b100;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic                         valid;
        logic                         regWrite;
        logic                         aluSrc;
        logic                         memWrite;
        logic                         jump;
        logic                         branch;
        InstructionSubTypes           subtype;
        logic [CTRL_RESULT_SRC_W-1:0] resultSrc;
        logic [CTRL_REG_ADDR_W-1:0]   rs1;
        logic [CTRL_REG_ADDR_W-1:0]   rs2;
        logic [CTRL_REG_ADDR_W-1:0]   rd;
    } ctrl_bundle_t;

    function automatic ctrl_bundle_t decodeCtrl(
        input logic                       valid,
        input InstructionTypes            instrType,
        input InstructionSubTypes         subType,
        input logic [CTRL_REG_ADDR_W-1:0] rs1,
        input logic [CTRL_REG_ADDR_W-1:0] rs2,
        input logic [CTRL_REG_ADDR_W-1:0] rd
    );
        ctrl_bundle_t b;
        b         = '0;
        b.valid   = valid;
        b.subtype = subType;
        b.rs1     = rs1;
        b.rs2     = rs2;
        b.rd      = rd;
        case (instrType)
            REG_COMPUTATION: b.regWrite = 1'b1;
            IMM_COMPUTATION: begin
                b.regWrite = 1'b1;
                b.aluSrc   = 1'b1;
            end
            LOAD: begin
                b.regWrite  = 1'b1;
                b.aluSrc    = 1'b1;
                b.resultSrc = RESULT_MEM;
            end
            STORE: begin
                b.memWrite = 1'b1;
                b.aluSrc   = 1'b1;
            end
            UPPER: begin
                b.regWrite = 1'b1;
                if (subType == LOAD_UPPER_IMM) begin
                    b.aluSrc    = 1'b1;
                    b.resultSrc = RESULT_IMM;
                end else begin
                    b.resultSrc = RESULT_PCIMM;
                end
            end
            JUMP: begin
                b.regWrite  = 1'b1;
                b.resultSrc = RESULT_PC4;
                b.jump      = 1'b1;
            end
            BRANCH:  b.branch = 1'b1;
            default: b.valid  = 1'b0;
        endcase
        if (!b.valid) b = '0;
        // x0 is hardwired, so a write to it is never a real producer
        if (b.rd == '0) b.regWrite = 1'b0;
        return b;
    endfunction
endpackage

// File: rtl/control_decode_pipe_hazard_unit.sv
// Combinational RAW hazard detection (stall request) and EX operand
// forwarding selects for the 5-stage control pipe.
module control_decode_pipe_hazard_unit
    import control_decode_pipe_pkg::*;
#(
    parameter int FWD_EN = 1
)(
    input  logic                       idValid,
    input  InstructionTypes            idType,
    input  logic [CTRL_REG_ADDR_W-1:0] idRs1,
    input  logic [CTRL_REG_ADDR_W-1:0] idRs2,
    input  logic                       exRegWrite,
    input  logic                       exIsLoad,
    input  logic [CTRL_REG_ADDR_W-1:0] exRd,
    input  logic [CTRL_REG_ADDR_W-1:0] exRs1,
    input  logic [CTRL_REG_ADDR_W-1:0] exRs2,
    input  logic                       memRegWrite,
    input  logic [CTRL_REG_ADDR_W-1:0] memRd,
    input  logic                       wbRegWrite,
    input  logic [CTRL_REG_ADDR_W-1:0] wbRd,
    input  logic                       pcSrc,
    output logic                       stall,
    output logic [1:0]                 fwdA,
    output logic [1:0]                 fwdB
);
    logic usesRs1, usesRs2, exHit, memHit, rawHazard;

    function automatic logic readsProducer(
        input logic                       we,
        input logic [CTRL_REG_ADDR_W-1:0] rd,
        input logic                       u1,
        input logic                       u2,
        input logic [CTRL_REG_ADDR_W-1:0] r1,
        input logic [CTRL_REG_ADDR_W-1:0] r2
    );
        return we && (rd != '0) && ((u1 && (rd == r1)) || (u2 && (rd == r2)));
    endfunction

    function automatic logic [1:0] fwdSel(input logic [CTRL_REG_ADDR_W-1:0] rs);
        if (memRegWrite && (memRd == rs)) return FWD_EXMEM;
        if (wbRegWrite && (wbRd == rs))   return FWD_MEMWB;
        return FWD_REG;
    endfunction

    always_comb begin
        usesRs1 = idValid && (idType != UPPER) && (idType != JUMP);
        usesRs2 = idValid && (idType inside {REG_COMPUTATION, STORE, BRANCH});
        exHit   = readsProducer(exRegWrite, exRd, usesRs1, usesRs2, idRs1, idRs2);
        memHit  = readsProducer(memRegWrite, memRd, usesRs1, usesRs2, idRs1, idRs2);
        // Without bypass paths every in-flight producer must drain first
        if (FWD_EN != 0) rawHazard = exHit && exIsLoad;
        else             rawHazard = exHit || memHit;
        stall = rawHazard && !pcSrc;
        fwdA  = FWD_REG;
        fwdB  = FWD_REG;
        if (FWD_EN != 0) begin
            fwdA = fwdSel(exRs1);
            fwdB = fwdSel(exRs2);
        end
    end
endmodule

// File: rtl/control_decode_pipe.sv
// Pipelined control decoder: decodes in ID and carries control through
// ID/EX, EX/MEM and MEM/WB with stall, forwarding and redirect squash.
module control_decode_pipe
    import control_decode_pipe_pkg::*;
#(
    parameter int REG_ADDR_W   = CTRL_REG_ADDR_W,
    parameter int RESULT_SRC_W = CTRL_RESULT_SRC_W,
    parameter int FWD_EN       = 1
)(
    input  logic                    iClk,
    input  logic                    iRstN,
    input  logic                    iValid,
    input  InstructionTypes         iInstructionType,
    input  InstructionSubTypes      iInstructionSubType,
    input  logic [REG_ADDR_W-1:0]   iRs1,
    input  logic [REG_ADDR_W-1:0]   iRs2,
    input  logic [REG_ADDR_W-1:0]   iRd,
    input  logic                    iZero,
    output logic                    oStall,
    output logic                    oFlushIfId,
    output logic                    oPcSrc,
    output logic                    oExAluSrc,
    output logic [1:0]              oFwdA,
    output logic [1:0]              oFwdB,
    output logic                    oMemMemWrite,
    output logic                    oWbRegWrite,
    output logic [REG_ADDR_W-1:0]   oWbRd,
    output logic [RESULT_SRC_W-1:0] oWbResultSrc
);
    ctrl_bundle_t            idBundle;
    ctrl_bundle_t            idEx_p0;
    logic                    exMemRegWrite_p1, exMemMemWrite_p1;
    logic [REG_ADDR_W-1:0]   exMemRd_p1;
    logic [RESULT_SRC_W-1:0] exMemResultSrc_p1;
    logic                    memWbRegWrite_p2;
    logic [REG_ADDR_W-1:0]   memWbRd_p2;
    logic [RESULT_SRC_W-1:0] memWbResultSrc_p2;
    logic                    branchTaken, pcSrc, stall;

    assign idBundle = decodeCtrl(iValid, iInstructionType, iInstructionSubType, iRs1, iRs2, iRd);

    always_comb begin
        branchTaken = 1'b0;
        if (idEx_p0.subtype == BEQ)      branchTaken = iZero;
        else if (idEx_p0.subtype == BNE) branchTaken = !iZero;
        pcSrc = idEx_p0.valid && (idEx_p0.jump || (idEx_p0.branch && branchTaken));
    end

    control_decode_pipe_hazard_unit #(.FWD_EN(FWD_EN)) hazardUnit (
        .idValid     (idBundle.valid),
        .idType      (iInstructionType),
        .idRs1       (iRs1),
        .idRs2       (iRs2),
        .exRegWrite  (idEx_p0.regWrite),
        .exIsLoad    (idEx_p0.resultSrc == RESULT_MEM),
        .exRd        (idEx_p0.rd),
        .exRs1       (idEx_p0.rs1),
        .exRs2       (idEx_p0.rs2),
        .memRegWrite (exMemRegWrite_p1),
        .memRd       (exMemRd_p1),
        .wbRegWrite  (memWbRegWrite_p2),
        .wbRd        (memWbRd_p2),
        .pcSrc       (pcSrc),
        .stall       (stall),
        .fwdA        (oFwdA),
        .fwdB        (oFwdB)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            idEx_p0           <= '0;
            exMemRegWrite_p1  <= 1'b0;
            exMemMemWrite_p1  <= 1'b0;
            exMemRd_p1        <= '0;
            exMemResultSrc_p1 <= '0;
            memWbRegWrite_p2  <= 1'b0;
            memWbRd_p2        <= '0;
            memWbResultSrc_p2 <= '0;
        end else begin
            // ID -> ID/EX: a redirect or a stall replaces the ID instruction with a bubble
            if (pcSrc || stall) idEx_p0 <= '0;
            else                idEx_p0 <= idBundle;
            // ID/EX -> EX/MEM
            exMemRegWrite_p1  <= idEx_p0.regWrite;
            exMemMemWrite_p1  <= idEx_p0.memWrite;
            exMemRd_p1        <= idEx_p0.rd;
            exMemResultSrc_p1 <= idEx_p0.resultSrc;
            // EX/MEM -> MEM/WB
            memWbRegWrite_p2  <= exMemRegWrite_p1;
            memWbRd_p2        <= exMemRd_p1;
            memWbResultSrc_p2 <= exMemResultSrc_p1;
        end
    end

    assign oStall       = stall;
    assign oFlushIfId   = pcSrc;
    assign oPcSrc       = pcSrc;
    assign oExAluSrc    = idEx_p0.aluSrc;
    assign oMemMemWrite = exMemMemWrite_p1;
    assign oWbRegWrite  = memWbRegWrite_p2;
    assign oWbRd        = memWbRd_p2;
    assign oWbResultSrc = memWbResultSrc_p2;
endmodule

// File: tb/tb_control_decode_pipe.sv
// Bench for control_decode_pipe: a forwarding and a stall-only instance share
// stimulus and are checked every cycle against an instruction-level model.
module tb_control_decode_pipe;
    import control_decode_pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rstN;
    logic               iValid;
    InstructionTypes    iType;
    InstructionSubTypes iSub;
    logic [4:0]         iRs1, iRs2, iRd;
    logic               iZero;

    // index 0: FWD_EN=1, index 1: FWD_EN=0
    wire [1:0] oStall, oFlush, oPcSrc, oAluSrc, oMemWrite, oWbWrite;
    wire [1:0] oFwdA   [2];
    wire [1:0] oFwdB   [2];
    wire [4:0] oWbRd   [2];
    wire [2:0] oWbRes  [2];

    control_decode_pipe #(.FWD_EN(1)) dutFwd (
        .iClk(clk), .iRstN(rstN), .iValid(iValid), .iInstructionType(iType),
        .iInstructionSubType(iSub), .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd), .iZero(iZero),
        .oStall(oStall[0]), .oFlushIfId(oFlush[0]), .oPcSrc(oPcSrc[0]), .oExAluSrc(oAluSrc[0]),
        .oFwdA(oFwdA[0]), .oFwdB(oFwdB[0]), .oMemMemWrite(oMemWrite[0]),
        .oWbRegWrite(oWbWrite[0]), .oWbRd(oWbRd[0]), .oWbResultSrc(oWbRes[0])
    );

    control_decode_pipe #(.FWD_EN(0)) dutNoFwd (
        .iClk(clk), .iRstN(rstN), .iValid(iValid), .iInstructionType(iType),
        .iInstructionSubType(iSub), .iRs1(iRs1), .iRs2(iRs2), .iRd(iRd), .iZero(iZero),
        .oStall(oStall[1]), .oFlushIfId(oFlush[1]), .oPcSrc(oPcSrc[1]), .oExAluSrc(oAluSrc[1]),
        .oFwdA(oFwdA[1]), .oFwdB(oFwdB[1]), .oMemMemWrite(oMemWrite[1]),
        .oWbRegWrite(oWbWrite[1]), .oWbRd(oWbRd[1]), .oWbResultSrc(oWbRes[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int m, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", name, m, act, exp, $time);
        end
    endtask

    // Model: the raw instruction occupying each stage (0=EX, 1=MEM, 2=WB)
    typedef struct {
        logic               v;
        InstructionTypes    ty;
        InstructionSubTypes sub;
        logic [4:0]         rs1, rs2, rd;
    } instr_t;

    instr_t st [2][3];

    function automatic instr_t bubble();
        instr_t b;
        b.v = 1'b0; b.ty = REG_COMPUTATION; b.sub = SUB_NONE;
        b.rs1 = '0; b.rs2 = '0; b.rd = '0;
        return b;
    endfunction

    function automatic instr_t idInstr();
        instr_t b;
        b.v = iValid; b.ty = iType; b.sub = iSub;
        b.rs1 = iRs1; b.rs2 = iRs2; b.rd = iRd;
        return b;
    endfunction

    function automatic logic writes(input instr_t r);
        return r.v && (r.rd != 0) &&
               (r.ty inside {REG_COMPUTATION, IMM_COMPUTATION, LOAD, UPPER, JUMP});
    endfunction

    function automatic logic hits(input instr_t r);
        logic u1, u2;
        u1 = iValid && !(iType inside {UPPER, JUMP});
        u2 = iValid && (iType inside {REG_COMPUTATION, STORE, BRANCH});
        return writes(r) && ((u1 && r.rd == iRs1) || (u2 && r.rd == iRs2));
    endfunction

    function automatic logic mPcSrc(input int m);
        instr_t r;
        r = st[m][0];
        if (!r.v) return 1'b0;
        if (r.ty == JUMP) return 1'b1;
        if (r.ty == BRANCH && r.sub == BEQ) return iZero;
        if (r.ty == BRANCH && r.sub == BNE) return !iZero;
        return 1'b0;
    endfunction

    function automatic logic mRaw(input int m);
        if (m == 0) return (st[m][0].ty == LOAD) && hits(st[m][0]);
        return hits(st[m][0]) || hits(st[m][1]);
    endfunction

    function automatic int mFwd(input int m, input logic [4:0] rs);
        if (m == 1) return 0;
        if (writes(st[m][1]) && st[m][1].rd == rs) return 2;
        if (writes(st[m][2]) && st[m][2].rd == rs) return 1;
        return 0;
    endfunction

    function automatic int resSrc(input instr_t r);
        if (!r.v) return 0;
        case (r.ty)
            LOAD:    return 1;
            JUMP:    return 2;
            UPPER:   return (r.sub == LOAD_UPPER_IMM) ? 3 : 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic aluSrc(input instr_t r);
        return r.v && ((r.ty inside {IMM_COMPUTATION, LOAD, STORE}) ||
                       (r.ty == UPPER && r.sub == LOAD_UPPER_IMM));
    endfunction

    always @(posedge clk or negedge rstN) begin
        instr_t nx [2];
        if (!rstN) begin
            for (int m = 0; m < 2; m++)
                for (int k = 0; k < 3; k++) st[m][k] <= bubble();
        end else begin
            for (int m = 0; m < 2; m++) begin
                nx[m] = (iValid && !mPcSrc(m) && !mRaw(m)) ? idInstr() : bubble();
                st[m][2] <= st[m][1];
                st[m][1] <= st[m][0];
                st[m][0] <= nx[m];
            end
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            chk("stall",    m, oStall[m],    mRaw(m) && !mPcSrc(m));
            chk("pcSrc",    m, oPcSrc[m],    mPcSrc(m));
            chk("flush",    m, oFlush[m],    mPcSrc(m));
            chk("aluSrc",   m, oAluSrc[m],   aluSrc(st[m][0]));
            chk("fwdA",     m, oFwdA[m],     mFwd(m, st[m][0].rs1));
            chk("fwdB",     m, oFwdB[m],     mFwd(m, st[m][0].rs2));
            chk("memWrite", m, oMemWrite[m], st[m][1].v && st[m][1].ty == STORE);
            chk("wbWrite",  m, oWbWrite[m],  writes(st[m][2]));
            chk("wbRd",     m, oWbRd[m],     st[m][2].v ? int'(st[m][2].rd) : 0);
            chk("wbRes",    m, oWbRes[m],    resSrc(st[m][2]));
        end
    end

    task automatic drive(input logic v, input InstructionTypes t, input InstructionSubTypes s,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic z);
        @(posedge clk);
        #1;
        iValid = v; iType = t; iSub = s; iRs1 = r1; iRs2 = r2; iRd = rd; iZero = z;
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, REG_COMPUTATION, SUB_NONE, 0, 0, 0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int stallCnt [2];

    initial begin
        rstN = 1'b0; iValid = 1'b0; iType = REG_COMPUTATION; iSub = SUB_NONE;
        iRs1 = '0; iRs2 = '0; iRd = '0; iZero = 1'b0;
        stallCnt[0] = 0; stallCnt[1] = 0;
        repeat (2) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("rst_stall", m, oStall[m], 0);
            chk("rst_wbRd",  m, oWbRd[m],  0);
        end
        rstN = 1'b1;
        nop(1);

        // Load-use: LOAD x5, then ADD x6 = x5 + x2 held in ID while stalled
        drive(1'b1, LOAD, SUB_NONE, 1, 0, 5, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, REG_COMPUTATION, SUB_NONE, 5, 2, 6, 1'b0);
            for (int m = 0; m < 2; m++) if (oStall[m]) stallCnt[m]++;
            if (c == 0) begin
                chk("lu_stall0", 0, oStall[0], 1);
                chk("lu_stall1", 1, oStall[1], 1);
            end
            if (c == 1) chk("lu_bubble_alu", 0, oAluSrc[0], 0);
            if (c == 2) begin
                chk("lu_fwdA",   0, oFwdA[0],   1);
                chk("lu_wbRd",   0, oWbRd[0],   5);
                chk("lu_wbRes",  0, oWbRes[0],  1);
            end
        end
        chk("lu_stallcycles", 0, stallCnt[0], 1);
        chk("nf_stallcycles", 1, stallCnt[1], 2);
        nop(1);
        chk("lu_bubble_wb", 0, oWbWrite[0], 0);
        nop(3);

        // EX/MEM forward, MEM/WB forward, and x0 destination
        drive(1'b1, REG_COMPUTATION, SUB_NONE, 1, 2, 3, 1'b0);
        drive(1'b1, REG_COMPUTATION, SUB_NONE, 4, 3, 8, 1'b0);
        nop(1);
        chk("fw_exmem_B", 0, oFwdB[0], 2);
        chk("fw_exmem_A", 0, oFwdA[0], 0);
        nop(3);
        drive(1'b1, REG_COMPUTATION, SUB_NONE, 1, 2, 3, 1'b0);
        nop(1);
        drive(1'b1, REG_COMPUTATION, SUB_NONE, 4, 3, 8, 1'b0);
        nop(1);
        chk("fw_memwb_B", 0, oFwdB[0], 1);
        nop(3);
        drive(1'b1, REG_COMPUTATION, SUB_NONE, 1, 2, 0, 1'b0);
        drive(1'b1, REG_COMPUTATION, SUB_NONE, 4, 0, 8, 1'b0);
        nop(1);
        chk("fw_x0_B", 0, oFwdB[0], 0);
        nop(1);
        chk("x0_wbWrite", 0, oWbWrite[0], 0);
        nop(3);

        // Taken BEQ squashes the wrong-path IMM; BNE with zero=1 falls through
        drive(1'b1, BRANCH, BEQ, 10, 11, 0, 1'b0);
        drive(1'b1, IMM_COMPUTATION, SUB_NONE, 1, 0, 9, 1'b1);
        chk("beq_pcSrc", 0, oPcSrc[0], 1);
        chk("beq_flush", 1, oFlush[1], 1);
        nop(1);
        chk("beq_squash", 0, oAluSrc[0], 0);
        nop(2);
        chk("beq_squash_wb", 0, oWbWrite[0], 0);
        nop(1);
        drive(1'b1, BRANCH, BNE, 10, 11, 0, 1'b0);
        drive(1'b1, IMM_COMPUTATION, SUB_NONE, 1, 0, 9, 1'b1);
        chk("bne_pcSrc", 0, oPcSrc[0], 0);
        chk("bne_flush", 0, oFlush[0], 0);
        nop(1);
        chk("bne_keep", 0, oAluSrc[0], 1);
        nop(3);

        // JUMP in EX beats a RAW hazard in ID
        drive(1'b1, LOAD, SUB_NONE, 1, 0, 12, 1'b0);
        drive(1'b1, JUMP, SUB_NONE, 0, 0, 13, 1'b0);
        drive(1'b1, REG_COMPUTATION, SUB_NONE, 12, 13, 14, 1'b0);
        for (int m = 0; m < 2; m++) begin
            chk("prio_stall", m, oStall[m], 0);
            chk("prio_pcSrc", m, oPcSrc[m], 1);
        end
        nop(3);

        // AUIPC x7 reaches WB three cycles after ID
        drive(1'b1, UPPER, ADD_UPPER_IMM_PC, 0, 0, 7, 1'b0);
        nop(3);
        for (int m = 0; m < 2; m++) begin
            chk("auipc_wbWrite", m, oWbWrite[m], 1);
            chk("auipc_wbRd",    m, oWbRd[m],    7);
            chk("auipc_wbRes",   m, oWbRes[m],   4);
        end
        nop(2);

        // Asynchronous reset with LOAD in ID/EX and a dependent ADD in ID
        drive(1'b1, LOAD, SUB_NONE, 1, 0, 5, 1'b0);
        drive(1'b1, REG_COMPUTATION, SUB_NONE, 5, 2, 6, 1'b0);
        chk("pre_rst_stall", 0, oStall[0], 1);
        rstN = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("midrst_stall",  m, oStall[m],  0);
            chk("midrst_alu",    m, oAluSrc[m], 0);
            chk("midrst_pcSrc",  m, oPcSrc[m],  0);
            chk("midrst_wbW",    m, oWbWrite[m], 0);
        end
        nop(1);
        rstN = 1'b1;
        nop(1);
        drive(1'b1, REG_COMPUTATION, SUB_NONE, 5, 2, 6, 1'b0);
        for (int m = 0; m < 2; m++) begin
            chk("postrst_stall", m, oStall[m], 0);
            chk("postrst_pcSrc", m, oPcSrc[m], 0);
        end
        nop(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
